// File: rtl/case5_pipe.sv
// -----------------------------------------------------------------------------
// case5_pipe
//
// Multi-lane, registered evaluation of the case5 Boolean function with a
// DEPTH-entry output FIFO behind a valid/ready handshake.
//
// Each transaction carries LANES independent bit-lanes. Lane i of the input
// buses a..f produces lane i of the results x/y/z:
//   x = a | (d & (~b | ~c))
//   y = b & d & (~c | (a & f & ~e))
//   z = (c | d) & (~c | ~d | (b & (e | ~a | ~f)))
// The results are computed combinationally and written into the FIFO tail on
// the accepting edge. The consumer sees them from the FIFO head, so a
// transaction accepted into an empty FIFO appears one cycle later.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears FIFO and storage)
//   in_valid   in   producer has a transaction on a..f
//   in_ready   out  FIFO not full (no bypass when full, even with a pop)
//   a..f       in   LANES bits each, lane-aligned operands
//   out_valid  out  FIFO head holds a result
//   out_ready  in   consumer takes the head this cycle
//   x, y, z    out  LANES bits each, results at the FIFO head
//   level      out  FIFO occupancy, 0..DEPTH
//
// Optional build macro CASE5_PIPE_STATS_EN adds:
//   stat_clr   in   synchronous clear of stat_cnt (wins over increment)
//   stat_cnt   out  16-bit saturating count of pushes whose z has any lane set
// -----------------------------------------------------------------------------
module case5_pipe #(
   parameter int LANES = 4,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES-1:0]             a,
   input  logic [LANES-1:0]             b,
   input  logic [LANES-1:0]             c,
   input  logic [LANES-1:0]             d,
   input  logic [LANES-1:0]             e,
   input  logic [LANES-1:0]             f,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES-1:0]             x,
   output logic [LANES-1:0]             y,
   output logic [LANES-1:0]             z,
   output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef CASE5_PIPE_STATS_EN
   ,
   input  logic                         stat_clr,
   output logic [15:0]                  stat_cnt
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef struct packed {
      logic [LANES-1:0] x;
      logic [LANES-1:0] y;
      logic [LANES-1:0] z;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q,  level_d;
   entry_t          res;
   logic            push;
   logic            pop;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Per-lane case5 function, evaluated on the whole bus at once.
   always_comb begin
      res.x = a | (d & (~b | ~c));
      res.y = b & d & (~c | (a & f & ~e));
      res.z = (c | d) & (~c | ~d | (b & (e | ~a | ~f)));
   end

   assign in_ready  = (level_q != FULL_LVL);
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // NOTE: every signal assigned in a combinational block gets a default at
   // the top; a path that leaves one unassigned would infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: the storage array is deliberately reset so the head never shows X
   // from an unwritten slot and outputs read 0 as soon as reset asserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= res;
      end
   end

   // Head drives the outputs directly, so they hold while stalled.
   assign x     = mem_q[rd_ptr_q].x;
   assign y     = mem_q[rd_ptr_q].y;
   assign z     = mem_q[rd_ptr_q].z;
   assign level = level_q;

`ifdef CASE5_PIPE_STATS_EN
   logic [15:0] stat_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt_q <= '0;
      end else if (stat_clr) begin
         stat_cnt_q <= '0;
      end else if (push && (|res.z) && (stat_cnt_q != 16'hFFFF)) begin
         stat_cnt_q <= stat_cnt_q + 16'd1;
      end
   end

   assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: doc/case5_pipe.md
Name: case5_pipe

Overview:
- Parametrised, registered, multi-lane successor to the combinational case5 function.
- Evaluates the case5 Boolean function (inputs a..f, outputs x/y/z) on LANES independent bit-lanes per transaction.
- Results are buffered in a DEPTH-entry output FIFO behind a valid/ready handshake.
- Sits between a producer of packed a..f vectors and a consumer that may stall.

Parameters:
- LANES, 4, number of parallel bit-lanes evaluated per transaction (>=1)
- DEPTH, 4, output FIFO entries (>=2; need not be a power of 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a transaction on a..f
- in_ready  output  1  block can accept a transaction this cycle
- a, b, c, d, e, f  input  LANES each  lane i of each bus forms lane i's input
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  consumer accepts the head this cycle
- x, y, z  output  LANES each  FIFO-head results, lane-aligned with inputs
- level  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Per-lane function, bit i:
  - x = a | (d & (~b | ~c))
  - y = b & d & (~c | (a & f & ~e))
  - z = (c | d) & (~c | ~d | (b & (e | ~a | ~f)))
- Push condition: in_valid & in_ready. The result is computed combinationally from a..f and written into the FIFO tail on that clock edge.
- in_ready = (level != DEPTH). There is no full-bypass: when full, a same-cycle pop does not allow a push.
- Pop condition: out_valid & out_ready. The head advances on that clock edge.
- out_valid = (level != 0). x/y/z are driven directly from head storage and are stable while out_valid=1 and out_ready=0.
- Latency: a transaction accepted at edge N is visible on x/y/z with out_valid=1 after edge N when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one transaction per cycle sustained when not full.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both pointers advance.
- Pointers wrap from DEPTH-1 to 0. Explicit wrap compare, not a power-of-2 mask.
- level is incremented on push-only and decremented on pop-only.
- Reset (asynchronous, any time, including mid-stream):
  - rd_ptr = wr_ptr = 0, level = 0, out_valid = 0, in_ready = 1.
  - x/y/z read 0 (storage cleared).
  - All in-flight entries are discarded.
- Inputs a..f are ignored when in_valid=0. Storage is written only on push.
- No X propagation from unwritten entries: storage resets to 0.

Optional Feature:
- Macro: CASE5_PIPE_STATS_EN.
- Defined: adds ports stat_clr (input, 1) and stat_cnt (output, 16).
  - stat_cnt increments on each push whose computed z has any lane set.
  - It saturates at 16'hFFFF.
  - stat_clr=1 forces 0 on the next edge; clear has priority over increment.
  - Reset value 0.
- Undefined: ports and counter are absent. All other behaviour is identical.

Test Plan:
- Reset/idle: rst_n low for 3 cycles, then released -> out_valid=0, in_ready=1, level=0, x=y=z=0.
- Function check (LANES=4): lane0 a..f=0,1,0,1,0,0; lane1 all 0; lane2 all 1; lane3 a=1,b=1,c=1,d=1,e=0,f=1; push once, out_ready=1 -> next cycle out_valid=1, x=4'b1101, y=4'b1001, z=4'b0101.
- Fill/stall (DEPTH=4): out_ready=0, push 5 consecutive with in_valid=1 -> 4 accepted, in_ready=0 after the 4th, level=4. The 5th is held, and is accepted on the cycle after the first pop.
- Simultaneous push/pop at level=2 for 10 cycles -> level stays 2, outputs emerge in order, pointers wrap at least twice with no loss or duplication.
- Asynchronous reset asserted mid-edge with level=3 -> outputs clear immediately without a clock, level=0, and the 3 entries never appear.
- CASE5_PIPE_STATS_EN: push 3 transactions with z nonzero and 2 with z=0 -> stat_cnt=3. Assert stat_clr simultaneously with a z-nonzero push -> stat_cnt=0.
